// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array sequencer and the APB config register block.
package systolic_pkg;

    localparam int DEF_ADDR_W   = 11;
    localparam int DEF_DIM_W    = 5;
    localparam int DEF_BATCH_W  = 6;
    localparam int DEF_PIPE_LAT = 2;
    // Pass-relative cycle counter; L+N+1 stays below 2^8 for the default widths.
    localparam int CNT_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLOAD,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/systolic_sequencer_addr_gen.sv
// Loadable wrapping address counter: a load pulse yields count+1 consecutive valid addresses
// starting on the following cycle, with last marking the final one.
module addr_gen #(
    parameter int AW = 11,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load_i,
    input  logic [AW-1:0] start_i,
    input  logic [CW-1:0] count_i,
    output logic [AW-1:0] addr_o,
    output logic          valid_o,
    output logic          last_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          valid_q, valid_d;

    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        if (load_i) begin
            addr_d  = start_i;
            rem_d   = count_i;
            valid_d = 1'b1;
        end else if (valid_q) begin
            if (rem_q == '0) begin
                valid_d = 1'b0;
            end else begin
                addr_d = addr_q + AW'(1);
                rem_d  = rem_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
        end
    end

    assign addr_o  = addr_q;
    assign valid_o = valid_q;
    assign last_o  = valid_q && (rem_q == '0);

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one systolic-array pass: weight load, activation read stream, and partial-sum
// read/write streams delayed by the array's row+column propagation latency.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DIM_W    = DEF_DIM_W,
    parameter int BATCH_W  = DEF_BATCH_W,
    // Must be at least 2 so the partial-sum stream is launched after the pass has begun.
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               weight_transfer,
    input  logic               systolic_start,
    input  logic [DIM_W-1:0]   last_row,
    input  logic [DIM_W-1:0]   last_col,
    input  logic [ADDR_W-1:0]  activations_addr_start,
    input  logic [ADDR_W-1:0]  partialsums_addr_start,
    input  logic [BATCH_W-1:0] batch,
    input  logic               accumulate,
    output logic               weight_load,
    output logic               act_rd_en,
    output logic [ADDR_W-1:0]  act_rd_addr,
    output logic               ps_rd_en,
    output logic [ADDR_W-1:0]  ps_rd_addr,
    output logic               ps_wr_en,
    output logic [ADDR_W-1:0]  ps_wr_addr,
    output logic               ps_acc,
    output logic               busy,
    output logic               done
);

    localparam int LAT_W = DIM_W + 2;

    state_e              state_q, state_d;
    logic                wt_pend_q, wt_pend_d;
    logic                st_pend_q, st_pend_d;
    logic                accept_start;
    logic [ADDR_W-1:0]   ps_start_q;
    logic [BATCH_W-1:0]  batch_q;
    logic                acc_q;
    logic [LAT_W-1:0]    lat_q;
    logic [CNT_W-1:0]    t_q;
    logic                in_pass;
    logic                ps_load;
    logic                act_last;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_valid;
    logic                rd_last;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                wr_last_q;

    always_comb begin
        state_d      = state_q;
        wt_pend_d    = wt_pend_q | weight_transfer;
        st_pend_d    = st_pend_q | systolic_start;
        accept_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Weight requests win so a same-cycle start runs with the new weights.
                if (wt_pend_d) begin
                    state_d   = ST_WLOAD;
                    wt_pend_d = 1'b0;
                end else if (st_pend_d) begin
                    state_d      = ST_FEED;
                    st_pend_d    = 1'b0;
                    accept_start = 1'b1;
                end
            end
            ST_WLOAD: state_d = ST_IDLE;
            ST_FEED:  if (act_last) state_d = ST_DRAIN;
            ST_DRAIN: if (wr_last_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            wt_pend_q <= 1'b0;
            st_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wt_pend_q <= wt_pend_d;
            st_pend_q <= st_pend_d;
        end
    end

    // Config is captured at acceptance; t_q counts cycles since acceptance during the pass.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ps_start_q <= '0;
            batch_q    <= '0;
            acc_q      <= 1'b0;
            lat_q      <= '0;
            t_q        <= '0;
        end else if (accept_start) begin
            ps_start_q <= partialsums_addr_start;
            batch_q    <= batch;
            acc_q      <= accumulate;
            lat_q      <= LAT_W'(PIPE_LAT) + {2'b00, last_row} + {2'b00, last_col};
            t_q        <= CNT_W'(1);
        end else if (in_pass) begin
            t_q <= t_q + CNT_W'(1);
        end
    end

    assign in_pass = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    // Launching at L-1 puts the read stream at S+L and the delayed write stream at S+L+1.
    assign ps_load = in_pass && (t_q == (CNT_W'(lat_q) - CNT_W'(1)));

    addr_gen #(.AW(ADDR_W), .CW(BATCH_W)) u_act_gen (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (accept_start),
        .start_i (activations_addr_start),
        .count_i (batch),
        .addr_o  (act_rd_addr),
        .valid_o (act_rd_en),
        .last_o  (act_last)
    );

    addr_gen #(.AW(ADDR_W), .CW(BATCH_W)) u_ps_gen (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (ps_load),
        .start_i (ps_start_q),
        .count_i (batch_q),
        .addr_o  (rd_addr),
        .valid_o (rd_valid),
        .last_o  (rd_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_last_q <= 1'b0;
        end else begin
            wr_en_q   <= rd_valid;
            wr_addr_q <= rd_addr;
            wr_last_q <= rd_last;
        end
    end

    assign ps_rd_en    = rd_valid && acc_q;
    assign ps_rd_addr  = rd_addr;
    assign ps_wr_en    = wr_en_q;
    assign ps_wr_addr  = wr_addr_q;
    assign ps_acc      = acc_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign weight_load = (state_q == ST_WLOAD);

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: per-cycle comparison of all outputs against a
// hand-derived pass timeline (k = cycles after the acceptance cycle S).
module tb_systolic_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        weight_transfer = 1'b0;
    logic        systolic_start = 1'b0;
    logic [4:0]  last_row = '0;
    logic [4:0]  last_col = '0;
    logic [10:0] activations_addr_start = '0;
    logic [10:0] partialsums_addr_start = '0;
    logic [5:0]  batch = '0;
    logic        accumulate = 1'b0;
    logic        weight_load;
    logic        act_rd_en;
    logic [10:0] act_rd_addr;
    logic        ps_rd_en;
    logic [10:0] ps_rd_addr;
    logic        ps_wr_en;
    logic [10:0] ps_wr_addr;
    logic        ps_acc;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    systolic_sequencer dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .weight_transfer        (weight_transfer),
        .systolic_start         (systolic_start),
        .last_row               (last_row),
        .last_col               (last_col),
        .activations_addr_start (activations_addr_start),
        .partialsums_addr_start (partialsums_addr_start),
        .batch                  (batch),
        .accumulate             (accumulate),
        .weight_load            (weight_load),
        .act_rd_en              (act_rd_en),
        .act_rd_addr            (act_rd_addr),
        .ps_rd_en               (ps_rd_en),
        .ps_rd_addr             (ps_rd_addr),
        .ps_wr_en               (ps_wr_en),
        .ps_wr_addr             (ps_wr_addr),
        .ps_acc                 (ps_acc),
        .busy                   (busy),
        .done                   (done)
    );

    // Expected output vector k cycles after acceptance of a pass.
    // Layout: {wl, busy, done, act_en, act_addr, rd_en, rd_addr, wr_en, wr_addr, acc}
    function automatic logic [39:0] pass_expect(int k, int a, int p, int n, int l, logic acc);
        logic        ae, re, we;
        logic [10:0] aa, ra, wa;
        ae = (k >= 1) && (k <= n);
        re = acc && (k >= l) && (k <= l + n - 1);
        we = (k >= l + 1) && (k <= l + n);
        aa = ae ? 11'(a + k - 1) : 11'd0;
        ra = re ? 11'(p + k - l) : 11'd0;
        wa = we ? 11'(p + k - l - 1) : 11'd0;
        return {1'b0, (k >= 1) && (k <= l + n + 1), (k == l + n + 1),
                ae, aa, re, ra, we, wa, (k >= 1) ? acc : 1'b0};
    endfunction

    // Addresses are only meaningful while their enable is expected high.
    function automatic logic [39:0] observe(logic [39:0] e);
        return {weight_load, busy, done,
                act_rd_en, act_rd_addr & {11{e[36]}},
                ps_rd_en, ps_rd_addr & {11{e[24]}},
                ps_wr_en, ps_wr_addr & {11{e[12]}},
                ps_acc};
    endfunction

    task automatic set_cfg(int a, int p, int n, int row, int col, logic acc);
        activations_addr_start = 11'(a);
        partialsums_addr_start = 11'(p);
        batch                  = 6'(n - 1);
        last_row               = 5'(row);
        last_col               = 5'(col);
        accumulate             = acc;
    endtask

    task automatic test_reset();
        logic [39:0] got;
        @(negedge clk);
        got = observe(40'hFF_FFFF_FFFF);
        total++;
        if (got !== 40'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", got, 40'd0);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        got = observe(40'hFF_FFFF_FFFF);
        total++;
        if (got !== 40'd0) begin
            bad++;
            $display("FAIL reset_idle got=%h exp=%h", got, 40'd0);
        end
    endtask

    // Scenario 1, plus config inputs scrambled right after acceptance.
    task automatic test_basic();
        logic [39:0] e, got;
        @(negedge clk);
        set_cfg('h10, 'h20, 4, 0, 0, 1'b0);
        systolic_start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            e   = pass_expect(k, 'h10, 'h20, 4, 2, 1'b0);
            got = observe(e);
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL basic k=%0d got=%h exp=%h", k, got, e);
            end
            if (k == 1) begin
                systolic_start = 1'b0;
                set_cfg('h555, 'h333, 64, 31, 31, 1'b1);
            end
        end
    endtask

    task automatic test_accumulate();
        logic [39:0] e, got;
        @(negedge clk);
        set_cfg('h10, 'h20, 4, 4, 7, 1'b1);
        systolic_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) systolic_start = 1'b0;
            e   = pass_expect(k, 'h10, 'h20, 4, 13, 1'b1);
            got = observe(e);
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL accumulate k=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [39:0] e, got;
        @(negedge clk);
        set_cfg('h7FE, 'h7FF, 4, 0, 0, 1'b1);
        systolic_start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) systolic_start = 1'b0;
            e   = pass_expect(k, 'h7FE, 'h7FF, 4, 2, 1'b1);
            got = observe(e);
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL wrap k=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    // Weight request during a pass is deferred: IDLE at S+8, WLOAD at S+9.
    task automatic test_wt_midpass();
        logic [39:0] e, got;
        @(negedge clk);
        set_cfg('h40, 'h80, 4, 0, 0, 1'b0);
        systolic_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) systolic_start = 1'b0;
            e = pass_expect((k <= 8) ? k : 8, 'h40, 'h80, 4, 2, 1'b0);
            if (k == 9) e[39:38] = 2'b11;
            got = observe(e);
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL wt_midpass k=%0d got=%h exp=%h", k, got, e);
            end
            weight_transfer = (k == 2);
        end
    endtask

    // Weight+start together, then two starts during the pass produce one extra pass only.
    task automatic test_back_to_back();
        logic [39:0] e, got;
        int j;
        @(negedge clk);
        set_cfg('h100, 'h200, 4, 0, 0, 1'b0);
        weight_transfer = 1'b1;
        systolic_start  = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            j = k - 2;
            if (j <= 0)
                e = pass_expect(0, 'h100, 'h200, 4, 2, 1'b0);
            else if (j <= 8)
                e = pass_expect(j, 'h100, 'h200, 4, 2, 1'b0);
            else
                e = pass_expect(j - 8, 'h100, 'h200, 4, 2, 1'b0);
            if (k == 1) e[39:38] = 2'b11;
            got = observe(e);
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got, e);
            end
            weight_transfer = 1'b0;
            systolic_start  = (j == 3) || (j == 5);
        end
    endtask

    task automatic test_reset_drain();
        logic [39:0] e, got;
        @(negedge clk);
        set_cfg('h10, 'h20, 4, 4, 7, 1'b1);
        systolic_start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) systolic_start = 1'b0;
            e   = pass_expect(k, 'h10, 'h20, 4, 13, 1'b1);
            got = observe(e);
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL pre_abort k=%0d got=%h exp=%h", k, got, e);
            end
        end
        #1 resetn = 1'b0;
        #1 got = observe(40'hFF_FFFF_FFFF);
        total++;
        if (got !== 40'd0) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", got, 40'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            got = observe(40'hFF_FFFF_FFFF);
            total++;
            if (got !== 40'd0) begin
                bad++;
                $display("FAIL post_abort k=%0d got=%h exp=%h", k, got, 40'd0);
            end
        end
        set_cfg('h30, 'h60, 3, 1, 2, 1'b0);
        systolic_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) systolic_start = 1'b0;
            e   = pass_expect(k, 'h30, 'h60, 3, 5, 1'b0);
            got = observe(e);
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL rerun k=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_wrap();
        test_wt_midpass();
        test_back_to_back();
        test_reset_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
